// File: rtl/control_sequencer_if.sv
// Handshake and strobe bundle between the instruction decoder/datapath and the
// multi-cycle control sequencer.
interface control_sequencer_if #(
    parameter int unsigned OPCODE_W  = 3,
    parameter int unsigned BRANCH_W  = 2,
    parameter int unsigned SRC_SEL_W = 3
);
    logic                 stall;
    logic                 instr_valid;
    logic [OPCODE_W-1:0]  opcode;
    logic [BRANCH_W-1:0]  branch_type;
    logic                 z_flag;
    logic                 carry_flag;
    logic                 mem_rw;
    logic                 mem_ready;

    logic                 pc_load;
    logic                 pc_inc;
    logic                 alu_src_sel;
    logic                 reg_write;
    logic [SRC_SEL_W-1:0] reg_src_sel;
    logic                 flash_read;
    logic                 mem_req;
    logic                 mem_rw_out;
    logic                 retire;
    logic                 illegal_op;
    logic                 bus_error;

    // Sequencer side: consumes decode/status, issues control strobes
    modport master (
        input  stall, instr_valid, opcode, branch_type, z_flag, carry_flag,
               mem_rw, mem_ready,
        output pc_load, pc_inc, alu_src_sel, reg_write, reg_src_sel,
               flash_read, mem_req, mem_rw_out, retire, illegal_op, bus_error
    );

    // Core side: decoder, flash, RAM and datapath
    modport slave (
        output stall, instr_valid, opcode, branch_type, z_flag, carry_flag,
               mem_rw, mem_ready,
        input  pc_load, pc_inc, alu_src_sel, reg_write, reg_src_sel,
               flash_read, mem_req, mem_rw_out, retire, illegal_op, bus_error
    );
endinterface

// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer: FETCH/EXEC/MEM_ACC phases with flash wait
// states, RAM timeout, illegal-opcode trap and external stall.
module control_sequencer #(
    parameter int unsigned OPCODE_W    = 3,
    parameter int unsigned BRANCH_W    = 2,
    parameter int unsigned SRC_SEL_W   = 3,
    parameter int unsigned FLASH_WAIT  = 1,
    parameter int unsigned MEM_TIMEOUT = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    control_sequencer_if.master   bus
);
    localparam int unsigned WCNT_W = 4;
    localparam int unsigned TCNT_W = 8;

    localparam logic [OPCODE_W-1:0] OP_RR      = OPCODE_W'(0);
    localparam logic [OPCODE_W-1:0] OP_IMM     = OPCODE_W'(1);
    localparam logic [OPCODE_W-1:0] OP_LOADIMM = OPCODE_W'(2);
    localparam logic [OPCODE_W-1:0] OP_MEM     = OPCODE_W'(3);
    localparam logic [OPCODE_W-1:0] OP_BRANCH  = OPCODE_W'(4);

    localparam logic [BRANCH_W-1:0] BR_UNB  = BRANCH_W'(0);
    localparam logic [BRANCH_W-1:0] BR_BIZ  = BRANCH_W'(1);
    localparam logic [BRANCH_W-1:0] BR_BINZ = BRANCH_W'(2);
    localparam logic [BRANCH_W-1:0] BR_BIC  = BRANCH_W'(3);

    localparam logic [SRC_SEL_W-1:0] SRC_ALU = SRC_SEL_W'(0);
    localparam logic [SRC_SEL_W-1:0] SRC_RAM = SRC_SEL_W'(1);
    localparam logic [SRC_SEL_W-1:0] SRC_IMM = SRC_SEL_W'(2);

    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(FLASH_WAIT);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        EXEC    = 2'd2,
        MEM_ACC = 2'd3
    } state_t;

    state_t              state, state_nxt;
    logic [WCNT_W-1:0]   wcnt, wcnt_nxt;
    logic [TCNT_W-1:0]   tcnt, tcnt_nxt;
    logic                rw_lat, rw_lat_nxt;
    logic                take_branch;

    logic                 pc_load, pc_inc, alu_src_sel, reg_write;
    logic [SRC_SEL_W-1:0] reg_src_sel;
    logic                 flash_read, mem_req, mem_rw_out;
    logic                 retire, illegal_op, bus_error;

    // State and latched access context
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            wcnt   <= '0;
            tcnt   <= '0;
            rw_lat <= 1'b0;
        end else begin
            state  <= state_nxt;
            wcnt   <= wcnt_nxt;
            tcnt   <= tcnt_nxt;
            rw_lat <= rw_lat_nxt;
        end
    end

    // Next state and strobes; strobes depend on live flags/handshakes
    always_comb begin
        state_nxt   = state;
        wcnt_nxt    = wcnt;
        tcnt_nxt    = tcnt;
        rw_lat_nxt  = rw_lat;
        take_branch = 1'b0;
        pc_load     = 1'b0;
        pc_inc      = 1'b0;
        alu_src_sel = 1'b0;
        reg_write   = 1'b0;
        reg_src_sel = SRC_ALU;
        flash_read  = 1'b0;
        mem_req     = 1'b0;
        mem_rw_out  = 1'b0;
        retire      = 1'b0;
        illegal_op  = 1'b0;
        bus_error   = 1'b0;

        case (state)
            IDLE: state_nxt = FETCH;

            FETCH: begin
                flash_read = 1'b1;
                // Data is only trusted once the wait-state count has elapsed
                if (bus.instr_valid && (wcnt == WCNT_LAST)) begin
                    state_nxt = EXEC;
                    wcnt_nxt  = '0;
                end else if (wcnt != WCNT_LAST) begin
                    wcnt_nxt = wcnt + WCNT_W'(1);
                end
            end

            EXEC: begin
                if (!bus.stall) begin
                    case (bus.opcode)
                        OP_RR, OP_IMM: begin
                            reg_write   = 1'b1;
                            reg_src_sel = SRC_ALU;
                            alu_src_sel = (bus.opcode == OP_IMM);
                            pc_inc      = 1'b1;
                            retire      = 1'b1;
                            state_nxt   = FETCH;
                        end
                        OP_LOADIMM: begin
                            reg_write   = 1'b1;
                            reg_src_sel = SRC_IMM;
                            pc_inc      = 1'b1;
                            retire      = 1'b1;
                            state_nxt   = FETCH;
                        end
                        OP_BRANCH: begin
                            case (bus.branch_type)
                                BR_UNB:  take_branch = 1'b1;
                                BR_BIZ:  take_branch = bus.z_flag;
                                BR_BINZ: take_branch = ~bus.z_flag;
                                BR_BIC:  take_branch = bus.carry_flag;
                                default: take_branch = 1'b0;
                            endcase
                            pc_load   = take_branch;
                            pc_inc    = ~take_branch;
                            retire    = 1'b1;
                            state_nxt = FETCH;
                        end
                        OP_MEM: begin
                            rw_lat_nxt = bus.mem_rw;
                            tcnt_nxt   = '0;
                            state_nxt  = MEM_ACC;
                        end
                        default: begin
                            illegal_op = 1'b1;
                            pc_inc     = 1'b1;
                            state_nxt  = FETCH;
                        end
                    endcase
                end
            end

            MEM_ACC: begin
                mem_req    = 1'b1;
                mem_rw_out = rw_lat;
                // A ready arriving on the timeout cycle still completes normally
                if (bus.mem_ready) begin
                    pc_inc    = 1'b1;
                    retire    = 1'b1;
                    if (!rw_lat) begin
                        reg_write   = 1'b1;
                        reg_src_sel = SRC_RAM;
                    end
                    state_nxt = FETCH;
                end else if (tcnt == TCNT_LAST) begin
                    bus_error = 1'b1;
                    pc_inc    = 1'b1;
                    state_nxt = FETCH;
                end else begin
                    tcnt_nxt = tcnt + TCNT_W'(1);
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

    assign bus.pc_load     = pc_load;
    assign bus.pc_inc      = pc_inc;
    assign bus.alu_src_sel = alu_src_sel;
    assign bus.reg_write   = reg_write;
    assign bus.reg_src_sel = reg_src_sel;
    assign bus.flash_read  = flash_read;
    assign bus.mem_req     = mem_req;
    assign bus.mem_rw_out  = mem_rw_out;
    assign bus.retire      = retire;
    assign bus.illegal_op  = illegal_op;
    assign bus.bus_error   = bus_error;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: directed per-cycle vectors push the
// hand-computed strobe pattern; a negedge monitor pops and compares.
module tb_control_sequencer;
    localparam int unsigned FW = 1;
    localparam int unsigned MT = 4;

    typedef struct packed {
        logic       pc_load;
        logic       pc_inc;
        logic       alu_src_sel;
        logic       reg_write;
        logic [2:0] reg_src_sel;
        logic       flash_read;
        logic       mem_req;
        logic       mem_rw_out;
        logic       retire;
        logic       illegal_op;
        logic       bus_error;
    } out_t;

    logic clk;
    logic reset;

    control_sequencer_if #(.OPCODE_W(3), .BRANCH_W(2), .SRC_SEL_W(3)) sif ();

    control_sequencer #(
        .OPCODE_W(3), .BRANCH_W(2), .SRC_SEL_W(3),
        .FLASH_WAIT(FW), .MEM_TIMEOUT(MT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    out_t  exp_q[$];
    string tag_q[$];
    bit    stim_done;
    int    checks;
    int    failures;
    int    cyc;
    int    drain;

    out_t E_Z, E_F, E_RR, E_IMM, E_LDI, E_BT, E_BN, E_MA0, E_MA1;
    out_t E_LDD, E_STD, E_ERR1, E_ILL;

    function automatic out_t mk(input logic pl, pi, alu, rw, input logic [2:0] src,
                                input logic fr, mr, mrw, ret, ill, be);
        mk = {pl, pi, alu, rw, src, fr, mr, mrw, ret, ill, be};
    endfunction

    // Drive one cycle of inputs just after the edge and queue its expected strobes
    task automatic step(input string tag, input logic rst, stl, vld,
                        input logic [2:0] op, input logic [1:0] bt,
                        input logic z, c, rw, rdy, input out_t e);
        @(posedge clk);
        #1;
        reset           = rst;
        sif.stall       = stl;
        sif.instr_valid = vld;
        sif.opcode      = op;
        sif.branch_type = bt;
        sif.z_flag      = z;
        sif.carry_flag  = c;
        sif.mem_rw      = rw;
        sif.mem_ready   = rdy;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic fetch2(input string tag);
        step({tag, "_f0"}, 1'b1, 1'b0, 1'b1, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_F);
        step({tag, "_f1"}, 1'b1, 1'b0, 1'b1, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_F);
    endtask

    task automatic ex(input string tag, input logic [2:0] op, input logic [1:0] bt,
                      input logic z, c, rw, rdy, input out_t e);
        step(tag, 1'b1, 1'b0, 1'b1, op, bt, z, c, rw, rdy, e);
    endtask

    // Monitor: compare every queued expectation at the falling edge
    always @(negedge clk) begin
        out_t  act;
        out_t  e;
        string t;
        cyc = cyc + 1;
        act = {sif.pc_load, sif.pc_inc, sif.alu_src_sel, sif.reg_write, sif.reg_src_sel,
               sif.flash_read, sif.mem_req, sif.mem_rw_out, sif.retire, sif.illegal_op,
               sif.bus_error};
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            checks = checks + 1;
            if (act !== e) begin
                failures = failures + 1;
                $display("FAIL %s cyc=%0d actual=%b required=%b (pl pi alu rw src fr mr mrw ret ill be)",
                         t, cyc, act, e);
            end
        end
        if (stim_done) begin
            drain = drain + 1;
            if (exp_q.size() == 0 || drain > 10 || cyc > 5000) begin
                if (exp_q.size() != 0) begin
                    failures = failures + 1;
                    $display("FAIL drain pending=%0d required=0", exp_q.size());
                end
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $finish;
            end
        end else if (cyc > 5000) begin
            failures = failures + 1;
            $display("FAIL watchdog cyc=%0d required_below=5000", cyc);
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
    end

    initial begin
        checks = 0; failures = 0; cyc = 0; drain = 0; stim_done = 1'b0;
        reset = 1'b0;
        sif.stall = 1'b0; sif.instr_valid = 1'b0; sif.opcode = 3'd0;
        sif.branch_type = 2'd0; sif.z_flag = 1'b0; sif.carry_flag = 1'b0;
        sif.mem_rw = 1'b0; sif.mem_ready = 1'b0;

        //            pl  pi  alu rw  src   fr  mr  mrw ret ill be
        E_Z    = mk(0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 0);
        E_F    = mk(0, 0, 0, 0, 3'd0, 1, 0, 0, 0, 0, 0);
        E_RR   = mk(0, 1, 0, 1, 3'd0, 0, 0, 0, 1, 0, 0);
        E_IMM  = mk(0, 1, 1, 1, 3'd0, 0, 0, 0, 1, 0, 0);
        E_LDI  = mk(0, 1, 0, 1, 3'd2, 0, 0, 0, 1, 0, 0);
        E_BT   = mk(1, 0, 0, 0, 3'd0, 0, 0, 0, 1, 0, 0);
        E_BN   = mk(0, 1, 0, 0, 3'd0, 0, 0, 0, 1, 0, 0);
        E_MA0  = mk(0, 0, 0, 0, 3'd0, 0, 1, 0, 0, 0, 0);
        E_MA1  = mk(0, 0, 0, 0, 3'd0, 0, 1, 1, 0, 0, 0);
        E_LDD  = mk(0, 1, 0, 1, 3'd1, 0, 1, 0, 1, 0, 0);
        E_STD  = mk(0, 1, 0, 0, 3'd0, 0, 1, 1, 1, 0, 0);
        E_ERR1 = mk(0, 1, 0, 0, 3'd0, 0, 1, 1, 0, 0, 1);
        E_ILL  = mk(0, 1, 0, 0, 3'd0, 0, 0, 0, 0, 1, 0);

        // Reset held, then release into IDLE
        step("rst0", 1'b0, 1'b0, 1'b1, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_Z);
        step("rst1", 1'b0, 1'b0, 1'b1, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_Z);
        step("idle", 1'b1, 1'b0, 1'b1, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_Z);

        // Non-memory instructions, 3-cycle cadence
        fetch2("rr_a");  ex("rr_a",  3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_RR);
        fetch2("rr_b");  ex("rr_b",  3'd0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, E_RR);
        fetch2("imm");   ex("imm",   3'd1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_IMM);
        fetch2("ldi");   ex("ldi",   3'd2, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_LDI);

        // Branch conditions
        fetch2("binz0"); ex("binz_z0", 3'd4, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, E_BT);
        fetch2("binz1"); ex("binz_z1", 3'd4, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, E_BN);
        fetch2("bic1");  ex("bic_c1",  3'd4, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0, E_BT);
        fetch2("bic0");  ex("bic_c0",  3'd4, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, E_BN);
        fetch2("biz0");  ex("biz_z0",  3'd4, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, E_BN);
        fetch2("biz1");  ex("biz_z1",  3'd4, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, E_BT);
        fetch2("unb");   ex("unb",     3'd4, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_BT);

        // Flash wait: instr_valid late, early valid must not advance
        step("fw_v0a", 1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_F);
        step("fw_v0b", 1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_F);
        step("fw_v0c", 1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_F);
        step("fw_v1",  1'b1, 1'b0, 1'b1, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_F);
        ex("fw_rr", 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_RR);

        // Load, ready on 4th MEM_ACC cycle, mem_rw toggling meanwhile
        fetch2("ld");
        ex("ld_ex",  3'd3, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_Z);
        ex("ld_m0",  3'd3, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, E_MA0);
        ex("ld_m1",  3'd3, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_MA0);
        ex("ld_m2",  3'd3, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, E_MA0);
        ex("ld_m3",  3'd3, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, E_LDD);

        // Store with fast ready
        fetch2("st");
        ex("st_ex",  3'd3, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, E_Z);
        ex("st_m0",  3'd3, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_MA1);
        ex("st_m1",  3'd3, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, E_STD);

        // Store timeout
        fetch2("to");
        ex("to_ex",  3'd3, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, E_Z);
        ex("to_m0",  3'd3, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, E_MA1);
        ex("to_m1",  3'd3, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, E_MA1);
        ex("to_m2",  3'd3, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, E_MA1);
        ex("to_m3",  3'd3, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, E_ERR1);
        fetch2("post_to"); ex("post_to_rr", 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_RR);

        // Ready on the timeout cycle wins
        fetch2("tr");
        ex("tr_ex",  3'd3, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, E_Z);
        ex("tr_m0",  3'd3, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, E_MA1);
        ex("tr_m1",  3'd3, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, E_MA1);
        ex("tr_m2",  3'd3, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, E_MA1);
        ex("tr_m3",  3'd3, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, E_STD);

        // Illegal opcodes
        fetch2("ill6"); ex("ill6", 3'd6, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_ILL);
        fetch2("ill7"); ex("ill7", 3'd7, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_ILL);

        // Stall in EXEC for 5 cycles, then complete; stall during FETCH ignored
        step("stf0", 1'b1, 1'b1, 1'b1, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_F);
        step("stf1", 1'b1, 1'b1, 1'b1, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_F);
        for (int i = 0; i < 5; i++)
            step("stall", 1'b1, 1'b1, 1'b1, 3'd4, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_Z);
        step("stall_rel", 1'b1, 1'b0, 1'b1, 3'd4, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, E_BN);

        // Asynchronous reset during MEM_ACC
        fetch2("ar");
        ex("ar_ex",  3'd3, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, E_Z);
        ex("ar_m0",  3'd3, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, E_MA1);
        ex("ar_m1",  3'd3, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, E_MA1);
        step("ar_rst0", 1'b0, 1'b0, 1'b1, 3'd3, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, E_Z);
        step("ar_rst1", 1'b0, 1'b0, 1'b1, 3'd3, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, E_Z);
        step("ar_idle", 1'b1, 1'b0, 1'b1, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_Z);
        fetch2("ar_post"); ex("ar_post_rr", 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_RR);

        stim_done = 1'b1;
    end
endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Multi-cycle successor to the single-cycle control decoder; drives PC, ALU source, register-file write, flash fetch and data-RAM access strobes.
- Sequences each instruction through FETCH/EXEC/MEM phases with wait-state handshakes to flash and RAM.
- Adds bus timeout, illegal-opcode trap and an external stall.
- Sits between the instruction decoder and the datapath in the core.

Parameters:
OPCODE_W, 3, opcode width; opcodes 0..4 legal (RR, IMM, LOADIMM, MEM, BRANCH), all others illegal
BRANCH_W, 2, branch_type width; 0 UNB, 1 BIZ, 2 BINZ, 3 BIC, others never taken
SRC_SEL_W, 3, width of reg_src_sel
FLASH_WAIT, 1, minimum FETCH cycles before instr_valid is accepted (0..15)
MEM_TIMEOUT, 8, MEM_ACC cycles without mem_ready before bus error (1..255)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
stall  input  1  hold sequencer in EXEC, no strobes
instr_valid  input  1  flash data valid
opcode  input  OPCODE_W  decoded opcode
branch_type  input  BRANCH_W  branch condition
z_flag  input  1  ALU zero flag
carry_flag  input  1  ALU carry flag
mem_rw  input  1  1 = store, 0 = load
mem_ready  input  1  RAM access complete
pc_load  output  1  load PC with branch target
pc_inc  output  1  increment PC
alu_src_sel  output  1  0 register operand, 1 immediate
reg_write  output  1  register-file write enable
reg_src_sel  output  SRC_SEL_W  write-back mux: 0 ALU, 1 RAM, 2 immediate
flash_read  output  1  flash read request
mem_req  output  1  RAM access request
mem_rw_out  output  1  latched access direction
retire  output  1  one-cycle pulse per completed instruction
illegal_op  output  1  one-cycle pulse on illegal opcode
bus_error  output  1  one-cycle pulse on RAM timeout

Behaviour:
- State register: IDLE, FETCH, EXEC, MEM_ACC. Outputs are combinational from state, latched registers and inputs.
- Reset (reset=0, asynchronous): state=IDLE, wcnt=0, tcnt=0, rw_lat=0. Every output is 0, including when reset is asserted mid-instruction. No strobe is emitted on the reset edge.
- IDLE: all outputs 0; next state FETCH.
- FETCH:
  - flash_read=1.
  - wcnt increments each cycle and saturates at FLASH_WAIT.
  - Go to EXEC when instr_valid=1 and wcnt==FLASH_WAIT, clearing wcnt.
  - instr_valid arriving earlier is ignored; stay in FETCH.
- EXEC with stall=1: no strobes, remain in EXEC; opcode/flags re-sampled each cycle.
- EXEC with stall=0, decode opcode (single cycle each):
  - RR: reg_write=1, reg_src_sel=0, alu_src_sel=0, pc_inc=1, retire=1 -> FETCH.
  - IMM: same as RR but alu_src_sel=1.
  - LOADIMM: reg_write=1, reg_src_sel=2, pc_inc=1, retire=1 -> FETCH.
  - BRANCH: pc_load = 1 (UNB) / z_flag (BIZ) / ~z_flag (BINZ) / carry_flag (BIC) / 0 (other). pc_inc=~pc_load, retire=1 -> FETCH. pc_load and pc_inc are never both 1.
  - MEM: rw_lat<=mem_rw, tcnt<=0 -> MEM_ACC. No strobes this cycle.
  - Illegal opcode: illegal_op=1, pc_inc=1, no reg_write, no retire -> FETCH.
- MEM_ACC:
  - mem_req=1, mem_rw_out=rw_lat. mem_rw changes during this state are ignored.
  - On mem_ready=1: pc_inc=1, retire=1. If rw_lat=0 also reg_write=1 and reg_src_sel=1. -> FETCH.
  - Otherwise tcnt increments. When tcnt==MEM_TIMEOUT-1 and mem_ready=0: bus_error=1, pc_inc=1, no reg_write, no retire -> FETCH.
  - mem_ready on the same cycle as the timeout wins: normal completion, no bus_error.
- stall is ignored outside EXEC.
- Throughput: FLASH_WAIT+2 cycles for non-memory instructions; FLASH_WAIT+3+(ready latency) cycles for MEM.

Test Plan:
- Reset release, FLASH_WAIT=1, instr_valid=1 constantly, opcode=RR -> flash_read on cycles 1-2; EXEC on cycle 3 shows reg_write=1, pc_inc=1, retire=1, reg_src_sel=0; pattern repeats every 3 cycles.
- opcode=BRANCH, branch_type=BINZ: z_flag=0 -> pc_load=1, pc_inc=0; z_flag=1 -> pc_load=0, pc_inc=1. branch_type=BIC, carry_flag=1 -> pc_load=1.
- opcode=MEM, mem_rw=0, mem_ready after 3 cycles (mem_rw toggled meanwhile) -> mem_req high 4 cycles, mem_rw_out=0 throughout; final cycle reg_write=1, reg_src_sel=1, pc_inc=1.
- opcode=MEM, mem_rw=1, MEM_TIMEOUT=4, mem_ready never -> mem_req 4 cycles, bus_error pulse on 4th with pc_inc=1, reg_write=0, retire=0. Repeat with mem_ready on the 4th cycle -> completion, bus_error=0.
- opcode=6 -> illegal_op=1, pc_inc=1, reg_write=0 for one cycle. stall=1 for 5 cycles in EXEC -> no strobes; after release the instruction completes.
- Assert reset during MEM_ACC -> mem_req and all outputs drop to 0 immediately (asynchronous); after release, sequence restarts from IDLE.
